// File: rtl/simon_decrypt_pipeline.sv
// Simon 32/64 decryptor, fully unrolled with one inverse Feistel round per stage.
// Round keys are expanded once after reset by a small sequential key-schedule engine.
module simon_decrypt_pipeline #(
  parameter logic [63:0] KEY    = 64'h1918_1110_0908_0100,
  parameter int          ROUNDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        in_valid,
  input  logic [31:0] ciphertext,
  output logic        ready,
  output logic        out_valid,
  output logic [31:0] plaintext
);

  // z0 sequence written left to right, so sequence bit j sits at vector bit 61-j.
  localparam logic [61:0] Z0_SEQ =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  // z bit needed when producing rk[i] is z0[i-4]; tabulated by i for a direct lookup.
  function automatic logic [31:0] z_table();
    logic [31:0] t;
    t = '0;
    for (int i = 4; i < 32; i++) begin
      t[i] = Z0_SEQ[65-i];
    end
    return t;
  endfunction

  localparam logic [31:0] Z_TAB = z_table();

  function automatic logic [15:0] ror3(input logic [15:0] v);
    return {v[2:0], v[15:3]};
  endfunction

  function automatic logic [15:0] ror1(input logic [15:0] v);
    return {v[0], v[15:1]};
  endfunction

  function automatic logic [15:0] f_mix(input logic [15:0] v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  typedef enum logic [1:0] {
    KS_LOAD,
    KS_EXPAND,
    KS_DONE
  } ks_state_t;

  ks_state_t   state_reg;
  ks_state_t   state_next;
  logic [4:0]  idx_reg;
  logic        ready_reg;
  logic [15:0] rk_reg [ROUNDS];
  logic        load_en;
  logic        expand_en;
  logic        done;
  logic [15:0] tmp_a;
  logic [15:0] tmp_b;
  logic [15:0] rk_new;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= KS_LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      KS_LOAD:   state_next = KS_EXPAND;
      KS_EXPAND: if (idx_reg == 5'd31) state_next = KS_DONE;
      KS_DONE:   state_next = KS_DONE;
      default:   state_next = KS_LOAD;
    endcase
  end

  always_comb begin
    load_en   = 1'b0;
    expand_en = 1'b0;
    done      = 1'b0;
    case (state_reg)
      KS_LOAD:   load_en   = 1'b1;
      KS_EXPAND: expand_en = 1'b1;
      KS_DONE:   done      = 1'b1;
      default:   load_en   = 1'b0;
    endcase
  end

  always_comb begin
    tmp_a  = ror3(rk_reg[idx_reg - 5'd1]) ^ rk_reg[idx_reg - 5'd3];
    tmp_b  = tmp_a ^ ror1(tmp_a);
    rk_new = ~rk_reg[idx_reg - 5'd4] ^ tmp_b ^ {15'd0, Z_TAB[idx_reg]} ^ 16'h0003;
  end

  // ready is registered off DONE, so it rises one edge after the last key is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg   <= 5'd0;
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= done;
      if (load_en) begin
        idx_reg <= 5'd4;
      end else if (expand_en) begin
        idx_reg <= idx_reg + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_en && !rst) begin
      rk_reg[0] <= KEY[15:0];
      rk_reg[1] <= KEY[31:16];
      rk_reg[2] <= KEY[47:32];
      rk_reg[3] <= KEY[63:48];
    end else if (expand_en && !rst) begin
      rk_reg[idx_reg] <= rk_new;
    end
  end

  // Slot 0 is the capture register; slot s+1 holds the result of decrypt round s.
  logic [15:0]   x_reg  [ROUNDS+1];
  logic [15:0]   y_reg  [ROUNDS+1];
  logic [ROUNDS:0] valid_reg;
  logic [15:0]   x_next [ROUNDS];
  logic [15:0]   y_next [ROUNDS];

  generate
    for (genvar gi = 0; gi < ROUNDS; gi++) begin : g_round
      assign x_next[gi] = y_reg[gi];
      assign y_next[gi] = x_reg[gi] ^ f_mix(y_reg[gi]) ^ rk_reg[ROUNDS-1-gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
      for (int s = 0; s <= ROUNDS; s++) begin
        x_reg[s] <= 16'd0;
        y_reg[s] <= 16'd0;
      end
    end else if (ce) begin
      valid_reg <= {valid_reg[ROUNDS-1:0], in_valid & ready_reg};
      x_reg[0]  <= ciphertext[31:16];
      y_reg[0]  <= ciphertext[15:0];
      for (int s = 0; s < ROUNDS; s++) begin
        x_reg[s+1] <= x_next[s];
        y_reg[s+1] <= y_next[s];
      end
    end
  end

  assign ready     = ready_reg;
  assign out_valid = valid_reg[ROUNDS];
  assign plaintext = {x_reg[ROUNDS], y_reg[ROUNDS]};

endmodule

// File: tb/tb_simon_decrypt_pipeline.sv
// Bench for simon_decrypt_pipeline: known-answer vectors plus randomized traffic
// checked against a round-level Simon 32/64 model and an enabled-cycle scoreboard.
module tb_simon_decrypt_pipeline;

  localparam logic [63:0] KEY = 64'h1918_1110_0908_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        in_valid;
  logic [31:0] ciphertext;
  logic        ready;
  logic        out_valid;
  logic [31:0] plaintext;

  always #5 clk = ~clk;

  simon_decrypt_pipeline #(.KEY(KEY), .ROUNDS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .in_valid   (in_valid),
    .ciphertext (ciphertext),
    .ready      (ready),
    .out_valid  (out_valid),
    .plaintext  (plaintext)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [15:0] rk [32];

  typedef struct {
    int          t;
    logic [31:0] pt;
  } blk_t;

  blk_t        pend[$];
  int          ecount    = 0;
  int          since_rst = 0;
  logic        exp_ready = 1'b0;
  logic        exp_ov    = 1'b0;
  logic [31:0] exp_pt    = 32'd0;

  function automatic logic [15:0] rol(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] fr(input logic [15:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  task automatic build_keys();
    string       zs;
    logic [15:0] tmp;
    zs = "11111010001001010110000111001101111101000100101011000011100110";
    rk[0] = KEY[15:0];
    rk[1] = KEY[31:16];
    rk[2] = KEY[47:32];
    rk[3] = KEY[63:48];
    for (int i = 4; i < 32; i++) begin
      tmp = rol(rk[i-1], 13) ^ rk[i-3];
      tmp = tmp ^ rol(tmp, 15);
      rk[i] = ~rk[i-4] ^ tmp ^ ((zs[i-4] == 8'h31) ? 16'd1 : 16'd0) ^ 16'h0003;
    end
  endtask

  function automatic logic [31:0] encrypt(input logic [31:0] p);
    logic [15:0] x, y, t;
    x = p[31:16];
    y = p[15:0];
    for (int r = 0; r < 32; r++) begin
      t = x;
      x = y ^ fr(x) ^ rk[r];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [31:0] decrypt(input logic [31:0] c);
    logic [15:0] x, y, t;
    x = c[31:16];
    y = c[15:0];
    for (int r = 31; r >= 0; r--) begin
      t = y;
      y = x ^ fr(y) ^ rk[r];
      x = t;
    end
    return {x, y};
  endfunction

  // Drive one clock and advance the scoreboard: a block accepted on enabled
  // cycle n emerges after enabled cycle n+32; ce=0 freezes everything.
  task automatic step(input logic r, input logic c, input logic v, input logic [31:0] ct);
    logic rdy_before;
    blk_t b;
    rdy_before = exp_ready;
    rst        = r;
    ce         = c;
    in_valid   = v;
    ciphertext = ct;
    @(posedge clk);
    #1;
    if (r) begin
      pend.delete();
      since_rst = 0;
      ecount    = 0;
      exp_ready = 1'b0;
      exp_ov    = 1'b0;
      exp_pt    = 32'd0;
    end else begin
      since_rst++;
      if (c) begin
        ecount++;
        if (v && rdy_before) begin
          b.t  = ecount;
          b.pt = decrypt(ct);
          pend.push_back(b);
        end
        exp_ov = 1'b0;
        if (pend.size() > 0 && pend[0].t + 32 == ecount) begin
          exp_ov = 1'b1;
          exp_pt = pend[0].pt;
          void'(pend.pop_front());
          $display("block out: plaintext=%h (enabled cycle %0d)", exp_pt, ecount);
        end
      end
      exp_ready = (since_rst >= 30);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b1, $urandom);
    n_vec++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b want 0", out_valid); end
    n_vec++; if (plaintext !== 32'd0) begin n_fail++; $display("FAIL reset_pt: got %h want 0", plaintext); end
  endtask

  // in_valid held high while the key schedule runs; none of it may come out.
  task automatic test_gating();
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b1, $urandom);
      n_vec++; if (ready !== exp_ready) begin n_fail++; $display("FAIL gate_ready: step %0d got %b want %b", k, ready, exp_ready); end
    end
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b1, 1'b0, $urandom);
      n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gate_ov: step %0d got %b want 0", k, out_valid); end
    end
    n_vec++; if (ready !== 1'b1) begin n_fail++; $display("FAIL gate_ready_final: got %b want 1", ready); end
  endtask

  task automatic test_vector();
    int seen;
    seen = 0;
    step(1'b0, 1'b1, 1'b1, 32'hc69be9bb);
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 1'b1, 1'b0, $urandom);
      n_vec++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL vec_ov: step %0d got %b want %b", k, out_valid, exp_ov); end
      if (out_valid === 1'b1) begin
        seen++;
        n_vec++;
        if (k != 32 || plaintext !== 32'h65656877) begin
          n_fail++; $display("FAIL vec_pt: step %0d got %h want 65656877 at step 32", k, plaintext);
        end
      end
    end
    n_vec++; if (seen != 1) begin n_fail++; $display("FAIL vec_count: got %0d outputs want 1", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [3];
    logic [31:0] got[$];
    int          first;
    want[0] = 32'h65656877;
    want[1] = 32'h41424344;
    want[2] = 32'h345a6b7c;
    first = -1;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, encrypt(want[k]));
    for (int k = 3; k < 45; k++) begin
      step(1'b0, 1'b1, 1'b0, $urandom);
      n_vec++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL b2b_ov: step %0d got %b want %b", k, out_valid, exp_ov); end
      if (out_valid === 1'b1) begin
        if (first < 0) first = k;
        n_vec++; if (k - first != got.size()) begin n_fail++; $display("FAIL b2b_gap: step %0d got index %0d want %0d", k, got.size(), k - first); end
        got.push_back(plaintext);
      end
    end
    n_vec++; if (got.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_vec++; if (got[i] !== want[i]) begin n_fail++; $display("FAIL b2b_pt%0d: got %h want %h", i, got[i], want[i]); end
    end
  endtask

  task automatic test_bubble();
    logic [31:0] pa, pb;
    logic        pat[$];
    logic [31:0] dat[$];
    pa = $urandom;
    pb = $urandom;
    step(1'b0, 1'b1, 1'b1, encrypt(pa));
    step(1'b0, 1'b1, 1'b0, $urandom);
    step(1'b0, 1'b1, 1'b1, encrypt(pb));
    for (int k = 3; k < 45; k++) begin
      step(1'b0, 1'b1, 1'b0, $urandom);
      n_vec++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL bub_ov: step %0d got %b want %b", k, out_valid, exp_ov); end
      if (out_valid === 1'b1 || pat.size() > 0) begin
        pat.push_back(out_valid);
        dat.push_back(plaintext);
      end
    end
    n_vec++;
    if (pat.size() < 3 || pat[0] !== 1'b1 || pat[1] !== 1'b0 || pat[2] !== 1'b1) begin
      n_fail++; $display("FAIL bub_pattern: got %0d slots starting %b want 1,0,1", pat.size(), (pat.size() > 0) ? pat[0] : 1'bx);
    end else begin
      n_vec++; if (dat[0] !== pa) begin n_fail++; $display("FAIL bub_pt0: got %h want %h", dat[0], pa); end
      n_vec++; if (dat[2] !== pb) begin n_fail++; $display("FAIL bub_pt2: got %h want %h", dat[2], pb); end
    end
  endtask

  task automatic test_ce_stall();
    logic [31:0] p;
    int          seen_at;
    logic        stall;
    p = $urandom;
    seen_at = -1;
    step(1'b0, 1'b1, 1'b1, encrypt(p));
    for (int k = 1; k <= 50; k++) begin
      stall = (k >= 11 && k <= 15);
      step(1'b0, !stall, stall ? 1'($urandom_range(0, 1)) : 1'b0, $urandom);
      n_vec++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL stall_ov: step %0d got %b want %b", k, out_valid, exp_ov); end
      if (out_valid === 1'b1 && seen_at < 0) begin
        seen_at = k;
        n_vec++; if (plaintext !== p) begin n_fail++; $display("FAIL stall_pt: got %h want %h", plaintext, p); end
      end
    end
    n_vec++; if (seen_at != 37) begin n_fail++; $display("FAIL stall_latency: got %0d want 37", seen_at); end
  endtask

  task automatic test_reset_midflight();
    step(1'b0, 1'b1, 1'b1, $urandom);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1, $urandom);
    step(1'b1, 1'b1, 1'b1, $urandom);
    for (int k = 0; k < 45; k++) begin
      step(1'b0, 1'b1, 1'b0, $urandom);
      n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ov: step %0d got %b want 0", k, out_valid); end
      n_vec++; if (ready !== exp_ready) begin n_fail++; $display("FAIL mid_ready: step %0d got %b want %b", k, ready, exp_ready); end
    end
    test_vector();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom);
      n_vec++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL rnd_ov: step %0d got %b want %b", k, out_valid, exp_ov); end
      if (exp_ov) begin
        n_vec++; if (plaintext !== exp_pt) begin n_fail++; $display("FAIL rnd_pt: step %0d got %h want %h", k, plaintext, exp_pt); end
      end
    end
    for (int k = 0; k < 40; k++) begin
      step(1'b0, 1'b1, 1'b0, $urandom);
      n_vec++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL rnd_drain_ov: step %0d got %b want %b", k, out_valid, exp_ov); end
      if (exp_ov) begin
        n_vec++; if (plaintext !== exp_pt) begin n_fail++; $display("FAIL rnd_drain_pt: step %0d got %h want %h", k, plaintext, exp_pt); end
      end
    end
    n_vec++; if (pend.size() != 0) begin n_fail++; $display("FAIL rnd_leftover: got %0d pending want 0", pend.size()); end
  endtask

  initial begin
    rst        = 1'b1;
    ce         = 1'b0;
    in_valid   = 1'b0;
    ciphertext = 32'd0;
    build_keys();
    test_reset();
    test_gating();
    test_vector();
    test_back_to_back();
    test_bubble();
    test_ce_stall();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/simon_decrypt_pipeline.md
Name: simon_decrypt_pipeline

Overview:
Simon 32/64 block decryptor, fully unrolled, one Feistel round per pipeline stage. It is the inverse of simon_pipeline: it takes 32-bit ciphertext and returns 32-bit plaintext under a fixed 64-bit key. It accepts one block per enabled cycle. Round keys are expanded once from the KEY parameter by a sequential key-schedule engine after reset.

Parameters:
KEY, 64'h1918_1110_0908_0100, cipher key {k3,k2,k1,k0}; k0 = KEY[15:0].
ROUNDS, 32, number of rounds; fixed by Simon 32/64 and not to be overridden.

Ports:
clk  input  1  clock, all logic rising-edge.
rst  input  1  synchronous reset, active-high.
ce  input  1  pipeline advance enable; when 0 every stage and out_valid hold.
in_valid  input  1  ciphertext valid this cycle; sampled only when ce=1 and ready=1.
ciphertext  input  32  {x[15:0], y[15:0]}, x in the upper half.
ready  output  1  key schedule complete; inputs are ignored while 0.
out_valid  output  1  plaintext valid.
plaintext  output  32  {x, y} decrypted block.

Behaviour:
- Reset (rst=1 at a clk edge):
  - ready=0, out_valid=0, plaintext=0.
  - All stage valid bits are cleared; stage data registers are cleared to 0.
  - Key-schedule FSM goes to LOAD.
  - Reset mid-operation discards every in-flight block; no out_valid may follow from pre-reset inputs.
- Key-schedule FSM, states LOAD -> EXPAND -> DONE:
  - LOAD (1 cycle): rk[0..3] = KEY words; counter i=4.
  - EXPAND: one round key per cycle, i=4..31.
    - tmp = ror(rk[i-1],3) ^ rk[i-3]
    - tmp = tmp ^ ror(tmp,1)
    - rk[i] = ~rk[i-4] ^ tmp ^ z0[i-4] ^ 16'h0003
    - z0 is the standard 62-bit Simon sequence, bit 0 first: 11111010001001010110000111001101111101000100101011000011100110.
    - After i=31 the FSM moves to DONE.
  - DONE: ready=1 and stays 1 until the next rst.
  - Timing: ready rises on the 30th clk edge after the rst-release edge. The FSM ignores ce.
- Pipeline: stage s (s=0..31) uses round key rk[31-s].
  - Decrypt round: (x,y) -> (y, x ^ f(y) ^ k), where f(v) = (rol(v,1) & rol(v,8)) ^ rol(v,2).
  - All rotations are 16-bit.
- Latency: 32 enabled cycles from input capture to out_valid.
  - Stage 0 captures on the ce=1 edge where in_valid=1 and ready=1.
  - plaintext and out_valid are registered outputs of stage 31.
- Throughput: one block per ce=1 cycle; back-to-back inputs produce back-to-back outputs.
- Bubbles: in_valid=0 propagates as a valid=0 bubble. The data register may still load, but out_valid=0 for that slot.
- ce=0: no register changes. Outputs hold, including a held out_valid=1; the consumer must qualify on ce.
- ready=0: captured valid is forced to 0 regardless of in_valid.
- Simultaneous rst and ce/in_valid: rst wins.
- No backpressure beyond ce; there is no overflow condition.

Test Plan:
1. Vector: rst, wait for ready, then ciphertext=32'hc69be9bb, in_valid=1 for one cycle -> 32 cycles later out_valid=1 for one cycle with plaintext=32'h65656877.
2. Back-to-back: 3 consecutive valid blocks (c69be9bb, then simon_pipeline outputs for 41424344 and 345a6b7c) -> 3 consecutive out_valid cycles returning 65656877, 41424344, 345a6b7c in order.
3. Bubble: valid, idle, valid -> out_valid pattern 1,0,1 with correct data in the valid slots.
4. ce stall: deassert ce for 5 cycles while a block is in flight -> outputs frozen during the stall; out_valid arrives 37 cycles after capture with correct data.
5. Reset mid-flight: rst for 1 cycle at stage 10 -> out_valid stays 0 until new inputs; ready=0 for 30 cycles, then the vector of scenario 1 decrypts correctly.
6. Gating: in_valid=1 while ready=0 -> no out_valid is ever produced for that input.
